// File: rtl/fht_host_seq.sv
// Frame-level host sequencer for the 4-bank radix-2 FHT core.
// Loads one N-point frame into RAM set A in bit-reversed order, starts the
// core, waits for it to finish and streams the results out in natural order
// through a 2-entry output buffer that absorbs downstream backpressure.
module fht_host_seq #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iDATA_VALID,
  output logic             oDATA_READY,
  output logic [3:0]       oWE_A,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic             oRD_SET,
  input  logic [D_BIT-1:0] iQ_0,
  input  logic [D_BIT-1:0] iQ_1,
  input  logic [D_BIT-1:0] iQ_2,
  input  logic [D_BIT-1:0] iQ_3,
  output logic             oBANK_OWN,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  input  logic             iFHT_SRC,
  output logic [D_BIT-1:0] oDATA,
  output logic             oDATA_VALID,
  input  logic             iDATA_READY,
  output logic             oBUSY
);

  localparam int K = A_BIT + 2;
  localparam logic [K-1:0] LAST = '1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;

  state_t           state;
  logic [K-1:0]     k_idx;
  logic [K-1:0]     k_rev;
  logic [K-1:0]     o_idx;
  logic [K-1:0]     rd_idx;
  logic             rd_done;
  logic             seen_low;
  logic             load_hs;
  logic             pop;
  logic             issue;
  logic [1:0]       occ;
  logic [1:0]       occ_room;
  logic             vld_p1;
  logic [1:0]       bank_p1;
  logic [D_BIT-1:0] q_p1;
  logic [D_BIT-1:0] buf_head;
  logic [D_BIT-1:0] buf_tail;

  function automatic logic [K-1:0] bitrev(input logic [K-1:0] v);
    logic [K-1:0] r;
    for (int i = 0; i < K; i++) r[i] = v[K-1-i];
    return r;
  endfunction

  assign load_hs     = oDATA_READY & iDATA_VALID;
  assign k_rev       = bitrev(k_idx);
  assign oADDR_RD    = rd_idx[K-1:2];
  assign oDATA       = buf_head;
  assign oDATA_VALID = (occ != 2'd0);
  assign pop         = oDATA_VALID & iDATA_READY;

  // A read may issue only if the slot it will occupy is guaranteed free,
  // counting the entry leaving the buffer this cycle.
  assign occ_room = (occ - {1'b0, pop}) + {1'b0, vld_p1};
  assign issue    = (state == UNLOAD) & ~rd_done & (occ_room < 2'd2);

  // Frame sequencing FSM with registered handshake/ownership outputs.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state       <= IDLE;
      oDATA_READY <= 1'b0;
      oFHT_START  <= 1'b0;
      oBANK_OWN   <= 1'b0;
      oBUSY       <= 1'b0;
      oRD_SET     <= 1'b0;
      seen_low    <= 1'b0;
      k_idx       <= '0;
      o_idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state       <= LOAD;
          oDATA_READY <= 1'b1;
          oBUSY       <= 1'b1;
        end
        LOAD: begin
          if (load_hs) begin
            if (k_idx == LAST) begin
              state       <= START;
              oDATA_READY <= 1'b0;
              oFHT_START  <= 1'b1;
              oBANK_OWN   <= 1'b1;
              k_idx       <= '0;
            end else begin
              k_idx <= k_idx + 1'b1;
            end
          end
        end
        START: begin
          oFHT_START <= 1'b0;
          seen_low   <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          // rdy may still be high right after start; only a low-then-high
          // sequence marks completion.
          if (!iFHT_RDY) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            oRD_SET   <= iFHT_SRC;
            oBANK_OWN <= 1'b0;
            state     <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (pop) begin
            if (o_idx == LAST) begin
              state <= IDLE;
              oBUSY <= 1'b0;
              o_idx <= '0;
            end else begin
              o_idx <= o_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port: strobe, address and data registered one cycle after a handshake.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oWE_A    <= 4'd0;
      oADDR_WR <= '0;
      oDATA_WR <= '0;
    end else if (load_hs) begin
      oWE_A    <= 4'd1 << k_rev[1:0];
      oADDR_WR <= k_rev[K-1:2];
      oDATA_WR <= iDATA;
    end else begin
      oWE_A <= 4'd0;
    end
  end

  // Read issue control: natural-order index and one-deep in-flight flag.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_idx  <= '0;
      rd_done <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == LAST) rd_done <= 1'b1;
      end else if (state != UNLOAD) begin
        rd_done <= 1'b0;
      end
    end
  end

  // Stage p1: bank select travels with the read to match RAM latency.
  always_ff @(posedge iCLK) begin
    if (issue) bank_p1 <= rd_idx[1:0];
  end

  // Pick the returning bank word.
  always_comb begin
    q_p1 = iQ_0;
    case (bank_p1)
      2'd0: q_p1 = iQ_0;
      2'd1: q_p1 = iQ_1;
      2'd2: q_p1 = iQ_2;
      default: q_p1 = iQ_3;
    endcase
  end

  // Two-entry FIFO output buffer; head drives oDATA.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= q_p1;
          else             buf_tail <= q_p1;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= q_p1;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= q_p1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_host_seq.sv
// Directed bench for fht_host_seq: load/start/run/unload frames with a
// registered bank-RAM model and queue-based scoreboards for writes and results.
module tb_fht_host_seq;

  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int N     = 4 * (2 ** A_BIT);

  logic             iCLK = 1'b0;
  logic             iRESET;
  logic [D_BIT-1:0] iDATA;
  logic             iDATA_VALID;
  logic             oDATA_READY;
  logic [3:0]       oWE_A;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA_WR;
  logic [A_BIT-1:0] oADDR_RD;
  logic             oRD_SET;
  logic [D_BIT-1:0] q0, q1, q2, q3;
  logic             oBANK_OWN;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             iFHT_SRC;
  logic [D_BIT-1:0] oDATA;
  logic             oDATA_VALID;
  logic             iDATA_READY;
  logic             oBUSY;

  fht_host_seq #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iDATA_VALID(iDATA_VALID),
    .oDATA_READY(oDATA_READY), .oWE_A(oWE_A), .oADDR_WR(oADDR_WR),
    .oDATA_WR(oDATA_WR), .oADDR_RD(oADDR_RD), .oRD_SET(oRD_SET),
    .iQ_0(q0), .iQ_1(q1), .iQ_2(q2), .iQ_3(q3),
    .oBANK_OWN(oBANK_OWN), .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
    .iFHT_SRC(iFHT_SRC), .oDATA(oDATA), .oDATA_VALID(oDATA_VALID),
    .iDATA_READY(iDATA_READY), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Bank RAM model: one-cycle registered read returning {bank, addr}.
  always @(posedge iCLK) begin
    q0 <= {6'd0, 2'd0, oADDR_RD};
    q1 <= {6'd0, 2'd1, oADDR_RD};
    q2 <= {6'd0, 2'd2, oADDR_RD};
    q3 <= {6'd0, 2'd3, oADDR_RD};
  end

  typedef struct packed {
    logic [3:0]       we;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
  } wr_t;

  wr_t              wq[$];
  logic [D_BIT-1:0] oq[$];
  logic [9:0]       k_mon;
  logic             stall_p;
  logic [D_BIT-1:0] held;

  function automatic wr_t exp_wr(input logic [9:0] k, input logic [D_BIT-1:0] d);
    logic [9:0] r;
    r = {<<{k}};
    return '{we: 4'b0001 << r[1:0], addr: r[9:2], data: d};
  endfunction

  // Write scoreboard: expectation pushed at handshake, checked next cycle.
  always @(negedge iCLK) begin
    if (!iRESET) begin
      wq.delete();
      k_mon <= 10'd0;
    end else begin
      if (wq.size() != 0) begin
        check("we_a", oWE_A, wq[0].we);
        check("addr_wr", oADDR_WR, wq[0].addr);
        check("data_wr", oDATA_WR, wq[0].data);
        void'(wq.pop_front());
        n_wr <= n_wr + 1;
      end else begin
        check("we_a_idle", oWE_A, 4'd0);
      end
      if (iDATA_VALID && oDATA_READY) begin
        wq.push_back(exp_wr(k_mon, iDATA));
        k_mon <= k_mon + 10'd1;
      end
    end
  end

  // Result scoreboard plus stall-stability check.
  always @(negedge iCLK) begin
    if (!iRESET) begin
      oq.delete();
      stall_p <= 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", oDATA_VALID, 1'b1);
        check("stall_data", oDATA, held);
      end
      if (oDATA_VALID && iDATA_READY) begin
        check("result_expected", 32'(oq.size() != 0), 32'd1);
        if (oq.size() != 0) begin
          check("result_data", oDATA, oq[0]);
          void'(oq.pop_front());
        end
        n_out <= n_out + 1;
      end
      stall_p <= oDATA_VALID && !iDATA_READY;
      held    <= oDATA;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, oDATA_READY, 1'b0);
    check({tag, "_we"}, oWE_A, 4'd0);
    check({tag, "_addr_wr"}, oADDR_WR, '0);
    check({tag, "_data_wr"}, oDATA_WR, '0);
    check({tag, "_addr_rd"}, oADDR_RD, '0);
    check({tag, "_rd_set"}, oRD_SET, 1'b0);
    check({tag, "_own"}, oBANK_OWN, 1'b0);
    check({tag, "_start"}, oFHT_START, 1'b0);
    check({tag, "_data"}, oDATA, '0);
    check({tag, "_valid"}, oDATA_VALID, 1'b0);
    check({tag, "_busy"}, oBUSY, 1'b0);
  endtask

  // Starts in an IDLE cycle; returns in the START cycle (or after an abort reset).
  task automatic load_frame(input int vpct, input int abort_at, output bit aborted);
    int  k = 0;
    int  cyc = 0;
    bit  hs;
    aborted = 1'b0;
    check("idle_busy", oBUSY, 1'b0);
    check("idle_ready", oDATA_READY, 1'b0);
    tick();
    while (k < N) begin
      if (abort_at >= 0 && k == abort_at) begin
        iDATA_VALID = 1'b0;
        iRESET = 1'b0;
        #1;
        check_reset("rst_mid");
        tick();
        check_reset("rst_hold");
        tick();
        iRESET = 1'b1;
        aborted = 1'b1;
        return;
      end
      iDATA_VALID = ($urandom_range(0, 99) < vpct);
      iDATA = 16'(k);
      hs = iDATA_VALID && oDATA_READY;
      check("load_ready", oDATA_READY, 1'b1);
      check("load_busy", oBUSY, 1'b1);
      check("load_no_start", oFHT_START, 1'b0);
      tick();
      cyc++;
      if (hs) k++;
      if (cyc > 20 * N) begin
        check("load_timeout", 32'(k), 32'(N));
        break;
      end
    end
    iDATA_VALID = 1'b0;
    if (vpct == 100) check("load_cycles", 32'(cyc), 32'(N));
    check("start_after_last", oFHT_START, 1'b1);
    check("start_own", oBANK_OWN, 1'b1);
    check("start_ready", oDATA_READY, 1'b0);
  endtask

  task automatic run_frame(input int vpct, input int rpct, input int run_len, input logic src);
    int wr0;
    int out0;
    int cyc;
    bit ab;
    logic [9:0] jj;
    wr0 = n_wr;
    load_frame(vpct, -1, ab);
    tick();
    // First RUN cycle: core rdy still high, must be ignored.
    check("start_pulse_width", oFHT_START, 1'b0);
    check("run_own_first", oBANK_OWN, 1'b1);
    tick();
    iFHT_RDY = 1'b0;
    iFHT_SRC = src;
    check("write_count", 32'(n_wr - wr0), 32'(N));
    check("rdy_high_ignored", oBANK_OWN, 1'b1);
    repeat (run_len) begin
      tick();
      check("run_own", oBANK_OWN, 1'b1);
      check("run_busy", oBUSY, 1'b1);
      check("run_valid", oDATA_VALID, 1'b0);
    end
    iFHT_RDY = 1'b1;
    out0 = n_out;
    for (int j = 0; j < N; j++) begin
      jj = 10'(j);
      oq.push_back({6'd0, jj[1:0], jj[9:2]});
    end
    tick();
    check("unload_own", oBANK_OWN, 1'b0);
    check("rd_set", oRD_SET, src);
    check("unload_busy", oBUSY, 1'b1);
    cyc = 0;
    while (oBUSY) begin
      iDATA_READY = (rpct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rpct);
      if (rpct >= 100 && cyc < 2) check("valid_startup", oDATA_VALID, 1'b0);
      if (rpct >= 100 && cyc == 2) check("first_valid", oDATA_VALID, 1'b1);
      tick();
      cyc++;
      if (cyc > 20 * N) begin
        check("unload_timeout", 32'(n_out - out0), 32'(N));
        break;
      end
    end
    iDATA_READY = 1'b1;
    if (rpct >= 100) check("unload_cycles", 32'(cyc), 32'(N + 2));
    check("result_count", 32'(n_out - out0), 32'(N));
    check("results_left", 32'(oq.size()), 32'd0);
    check("end_idle_valid", oDATA_VALID, 1'b0);
  endtask

  initial begin
    bit ab;
    iRESET      = 1'b1;
    iDATA       = '0;
    iDATA_VALID = 1'b0;
    iFHT_RDY    = 1'b1;
    iFHT_SRC    = 1'b0;
    iDATA_READY = 1'b1;
    #2 iRESET = 1'b0;
    repeat (3) tick();
    check_reset("por");
    iRESET = 1'b1;

    // Full frame, no stalls, long core run, result in set B.
    run_frame(100, 100, 2590, 1'b1);
    // Output backpressure at 30 % ready, result in set A.
    run_frame(100, 30, 40, 1'b0);
    // Input gaps at 50 % valid.
    run_frame(50, 100, 40, 1'b1);
    // Reset in the middle of LOAD, then a clean frame from k = 0.
    load_frame(100, 500, ab);
    check("abort_taken", 32'(ab), 32'd1);
    run_frame(100, 100, 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
